// File: rtl/mult_add_16_24_40_40_if.sv
// Operand/result bundle for the pipelined signed multiply-accumulate slice.
// The master drives the operands and controls; the slave returns p and pcout.
interface mult_add_16_24_40_40_if #(
   parameter int A_WIDTH     = 16,
   parameter int B_WIDTH     = 16,
   parameter int C_WIDTH     = 32,
   parameter int P_WIDTH     = 32,
   parameter int PCOUT_WIDTH = 48
);
   logic                   ce;
   logic                   subtract;
   logic [A_WIDTH-1:0]     a;
   logic [B_WIDTH-1:0]     b;
   logic [C_WIDTH-1:0]     c;
   logic [P_WIDTH-1:0]     p;
   logic [PCOUT_WIDTH-1:0] pcout;

   modport master (
      output ce, subtract, a, b, c,
      input  p, pcout
   );

   modport slave (
      input  ce, subtract, a, b, c,
      output p, pcout
   );
endinterface

// File: rtl/mult_add_16_24_40_40.sv
// Three-stage signed multiply-accumulate: pcout = c +/- a*b at 48 bits, p = low 32 bits.
// Every operand set carries its own subtract bit down the pipe; ce freezes all stages.
module mult_add_16_24_40_40 #(
   parameter int A_WIDTH     = 16,
   parameter int B_WIDTH     = 16,
   parameter int C_WIDTH     = 32,
   parameter int P_WIDTH     = 32,
   parameter int PCOUT_WIDTH = 48
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mult_add_16_24_40_40_if.slave  bus
);
   localparam int PROD_WIDTH = A_WIDTH + B_WIDTH;

   logic signed [A_WIDTH-1:0]     a1_reg;
   logic signed [B_WIDTH-1:0]     b1_reg;
   logic signed [C_WIDTH-1:0]     c1_reg;
   logic                          sub1_reg;

   logic signed [PROD_WIDTH-1:0]  prod2_reg;
   logic signed [C_WIDTH-1:0]     c2_reg;
   logic                          sub2_reg;

   logic signed [PCOUT_WIDTH-1:0] pcout_reg;

   logic signed [PROD_WIDTH-1:0]  prod_next;
   logic signed [PCOUT_WIDTH-1:0] c_ext;
   logic signed [PCOUT_WIDTH-1:0] prod_ext;
   logic signed [PCOUT_WIDTH-1:0] acc_next;

   always_comb begin
      prod_next = a1_reg * b1_reg;
      c_ext     = {{(PCOUT_WIDTH - C_WIDTH){c2_reg[C_WIDTH-1]}}, c2_reg};
      prod_ext  = {{(PCOUT_WIDTH - PROD_WIDTH){prod2_reg[PROD_WIDTH-1]}}, prod2_reg};
      acc_next  = sub2_reg ? (c_ext - prod_ext) : (c_ext + prod_ext);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_reg    <= '0;
         b1_reg    <= '0;
         c1_reg    <= '0;
         sub1_reg  <= 1'b0;
         prod2_reg <= '0;
         c2_reg    <= '0;
         sub2_reg  <= 1'b0;
         pcout_reg <= '0;
      end else if (bus.ce) begin
         a1_reg    <= bus.a;
         b1_reg    <= bus.b;
         c1_reg    <= bus.c;
         sub1_reg  <= bus.subtract;
         prod2_reg <= prod_next;
         c2_reg    <= c1_reg;
         sub2_reg  <= sub1_reg;
         pcout_reg <= acc_next;
      end
   end

   // p is a plain truncation: wraps modulo 2^P_WIDTH, never saturates.
   assign bus.p     = pcout_reg[P_WIDTH-1:0];
   assign bus.pcout = pcout_reg;
endmodule

// File: tb/tb_mult_add_16_24_40_40.sv
// Directed bench for the multiply-accumulate slice: streamed vector table plus
// hand-written reset, clock-enable and asynchronous-reset sequences.
module tb_mult_add_16_24_40_40;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] c;
      logic        sub;
      logic [31:0] exp_p;
      logic [47:0] exp_pcout;
   } vec_t;

   localparam int NVEC = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [NVEC];

   mult_add_16_24_40_40_if bus ();

   mult_add_16_24_40_40 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end else begin
         $display("ok   %s[%0d]: %h", name, idx, act);
      end
   endtask

   task automatic apply(input vec_t v, input logic ce_val);
      bus.a        = v.a;
      bus.b        = v.b;
      bus.c        = v.c;
      bus.subtract = v.sub;
      bus.ce       = ce_val;
   endtask

   task automatic idle();
      bus.a        = '0;
      bus.b        = '0;
      bus.c        = '0;
      bus.subtract = 1'b0;
      bus.ce       = 1'b1;
   endtask

   task automatic chk_vec(input string name, input int idx, input vec_t v);
      chk({name, "_p"}, idx, {16'h0, bus.p}, {16'h0, v.exp_p});
      chk({name, "_pcout"}, idx, bus.pcout, v.exp_pcout);
   endtask

   initial begin
      vec_t garbage;
      vecs[0]  = '{16'h4FFF, 16'h4FFF, 32'h4FFFFFFF, 1'b0, 32'h68FF6000, 48'h000068FF6000};
      vecs[1]  = '{16'h4FFF, 16'h4FFF, 32'h4FFFFFFF, 1'b1, 32'h37009FFE, 48'h000037009FFE};
      vecs[2]  = '{16'h4FFF, 16'h4FFF, 32'h4FFFFFFF, 1'b0, 32'h68FF6000, 48'h000068FF6000};
      vecs[3]  = '{16'h4FFF, 16'h4FFF, 32'h4FFFFFFF, 1'b1, 32'h37009FFE, 48'h000037009FFE};
      vecs[4]  = '{16'hFFF0, 16'h4000, 32'h00000000, 1'b0, 32'hFFFC0000, 48'hFFFFFFFC0000};
      vecs[5]  = '{16'hFFF0, 16'h4000, 32'h00000000, 1'b1, 32'h00040000, 48'h000000040000};
      vecs[6]  = '{16'h8000, 16'h8000, 32'h7FFFFFFF, 1'b0, 32'hBFFFFFFF, 48'h0000BFFFFFFF};
      vecs[7]  = '{16'h8000, 16'h8000, 32'h00000000, 1'b0, 32'h40000000, 48'h000040000000};
      vecs[8]  = '{16'h0000, 16'h04D2, 32'h12345678, 1'b1, 32'h12345678, 48'h000012345678};
      vecs[9]  = '{16'h0001, 16'h0001, 32'h80000000, 1'b0, 32'h80000001, 48'hFFFF80000001};
      vecs[10] = '{16'h7FFF, 16'h8000, 32'h00000000, 1'b1, 32'h3FFF8000, 48'h00003FFF8000};
      vecs[11] = '{16'h8000, 16'h8000, 32'h80000000, 1'b1, 32'h40000000, 48'hFFFF40000000};
      garbage  = '{16'h1111, 16'h2222, 32'h33333333, 1'b1, 32'h0, 48'h0};

      // Reset held with nonzero inputs
      rst_n = 1'b0;
      apply(vecs[0], 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_p", 0, {16'h0, bus.p}, 48'h0);
      chk("rst_pcout", 0, bus.pcout, 48'h0);
      rst_n = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      chk("idle_p", 0, {16'h0, bus.p}, 48'h0);
      chk("idle_pcout", 0, bus.pcout, 48'h0);

      // Streamed table: one vector per cycle, result checked 3 edges later
      for (int t = 0; t < NVEC + 3; t++) begin
         if (t >= 3) chk_vec("vec", t - 3, vecs[t - 3]);
         if (t < NVEC) apply(vecs[t], 1'b1);
         else idle();
         @(negedge clk);
      end

      // Clock-enable freeze mid-stream with junk on the inputs
      idle();
      repeat (3) @(negedge clk);
      apply(vecs[0], 1'b1);
      @(negedge clk);
      apply(vecs[1], 1'b1);
      @(negedge clk);
      apply(garbage, 1'b0);
      @(negedge clk);
      chk("ce_hold_pcout", 0, bus.pcout, 48'h0);
      @(negedge clk);
      chk("ce_hold_pcout", 1, bus.pcout, 48'h0);
      idle();
      @(negedge clk);
      chk_vec("ce_resume", 0, vecs[0]);
      @(negedge clk);
      chk_vec("ce_resume", 1, vecs[1]);
      @(negedge clk);
      chk("ce_drain_pcout", 0, bus.pcout, 48'h0);

      // Asynchronous reset between edges clears outputs immediately
      apply(vecs[6], 1'b1);
      repeat (3) @(negedge clk);
      chk_vec("pre_async", 0, vecs[6]);
      #2 rst_n = 1'b0;
      #1;
      chk("async_p", 0, {16'h0, bus.p}, 48'h0);
      chk("async_pcout", 0, bus.pcout, 48'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      chk("post_async_pcout", 0, bus.pcout, 48'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
